// File: rtl/vga_timing_pkg.sv
// Shared raster types and 640x480@60 default timing for the VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_SYNC_DLY = 2;
    localparam int MAX_TOTAL    = 1024;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Pixel-tick shift register that aligns the sync/blank triple with the painter's RGB pipeline.
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  shift,
    input  sync_t din,
    output sync_t dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, shift};
            assign dout = din;
        end else begin : g_shift
            sync_t stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= SYNC_IDLE;
                    end
                end else if (shift) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster coordinate generator with pixel-tick divider and delayed sync/blank strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int SYNC_DLY = DEF_SYNC_DLY
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output logic   pix_en,
    output coord_t hs,
    output coord_t vs,
    output logic   line_start,
    output logic   frame_start,
    output logic   hsync_n,
    output logic   vsync_n,
    output logic   blank_n
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t     H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t     V_LAST   = coord_t'(V_TOTAL - 1);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    // Strobe bounds kept at 11 bits so an edge sitting exactly at 1024 does not alias to 0.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 1024", H_TOTAL, V_TOTAL);
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV=%0d outside 1..16", CLK_DIV);
        end
        if (SYNC_DLY < 0 || SYNC_DLY > 8) begin : g_bad_dly
            $error("vga_timing_gen: SYNC_DLY=%0d outside 0..8", SYNC_DLY);
        end
    endgenerate

    logic [3:0]  div;
    logic [10:0] hs_x;
    logic [10:0] vs_x;
    sync_t       sync_raw;
    sync_t       sync_dly;

    assign pix_en      = en && !rst && (div == DIV_LAST);
    assign line_start  = pix_en && (hs == '0);
    assign frame_start = line_start && (vs == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? 4'd0 : 4'(div + 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs <= '0;
            vs <= '0;
        end else if (pix_en) begin
            if (hs == H_LAST) begin
                hs <= '0;
                vs <= (vs == V_LAST) ? coord_t'(0) : coord_t'(vs + 10'd1);
            end else begin
                hs <= coord_t'(hs + 10'd1);
            end
        end
    end

    assign hs_x = {1'b0, hs};
    assign vs_x = {1'b0, vs};

    always_comb begin
        sync_raw         = SYNC_IDLE;
        sync_raw.hsync_n = !((hs_x >= HS_START) && (hs_x < HS_END));
        sync_raw.vsync_n = !((vs_x >= VS_START) && (vs_x < VS_END));
        sync_raw.blank_n = (hs_x < H_ACT_END) && (vs_x < V_ACT_END);
    end

    sync_delay_line #(
        .DEPTH (SYNC_DLY)
    ) u_sync_dly (
        .clk   (clk),
        .rst   (rst),
        .shift (pix_en),
        .din   (sync_raw),
        .dout  (sync_dly)
    );

    assign hsync_n = sync_dly.hsync_n;
    assign vsync_n = sync_dly.vsync_n;
    assign blank_n = sync_dly.blank_n;

endmodule
